sparse_chunk_writer: RTL and testbench
======================================

SPARSE_CHUNK_WRITER -- requirements
Module: sparse_chunk_writer

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 8, meaning bytes per beat.
REQ-002 SHALL have parameter MEM_SIZE, default 32, meaning bytes per chunk; WR_DAT_CYC_NUM = ceil(MEM_SIZE/BUS_SIZE).
REQ-003 SHALL have parameter CHUNK_NUM, default 4, meaning maximum chunks per run.
REQ-004 SHALL have one clock, clk_i, and a synchronous, active-low reset, rst_i.
REQ-005 SHALL have ports, in order:
- clk_i  in  1  clock.
- rst_i  in  1  sync active-low reset.
- start_i  in  1  run request.
- target_i  in  1  0=IFM, 1=filter.
- chunk_num_i  in  clog2(CHUNK_NUM+1)  chunks this run.
- in_data_i  in  BUS_SIZE*8  dense bytes, byte 0 in LSBs.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted.
- wr_sparsemap_o  out  BUS_SIZE  bit b = 1 iff dense byte b is nonzero.
- wr_nonzero_data_o  out  BUS_SIZE*8  compacted nonzeros.
- wr_nonzero_cnt_o  out  clog2(BUS_SIZE+1)  popcount of the sparsemap.
- wr_valid_o  out  1  write beat valid.
- wr_ready_i  in  1  sink accepts.
- wr_target_o  out  1  latched target.
- wr_dat_count_o  out  clog2(WR_DAT_CYC_NUM)  beat index within chunk.
- wr_chunk_count_o  out  clog2(CHUNK_NUM)  chunk index.
- busy_o  out  1  run in progress.
- finish_o  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-007 In IDLE, start_i=1 SHALL latch target_i and chunk_num_i and go to RUN; if chunk_num_i is 0 or exceeds CHUNK_NUM, it SHALL go to DONE directly.
REQ-008 start_i SHALL be ignored outside IDLE.
REQ-009 Each input handshake (in_valid_i & in_ready_o) SHALL load one output register stage, giving latency 1 cycle to wr_valid_o.
REQ-010 Nonzero bytes SHALL be packed toward byte 0 in ascending source order; unused upper bytes SHALL be 0.
REQ-011 Each output SHALL hold stable while wr_valid_o=1 and wr_ready_i=0.
REQ-012 in_ready_o SHALL be 1 iff RUN & input beats accepted < chunk_num*WR_DAT_CYC_NUM & (output stage empty | wr_ready_i), allowing full throughput of 1 beat/cycle.
REQ-013 On the last beat of each chunk, when MEM_SIZE%BUS_SIZE != 0, bytes at chunk offset >= MEM_SIZE SHALL be forced to zero before compaction.
REQ-014 wr_dat_count_o and wr_chunk_count_o SHALL describe the current output beat and SHALL advance on the output handshake (wr_valid_o & wr_ready_i).
- dat_count SHALL wrap at WR_DAT_CYC_NUM-1, and chunk_count SHALL then increment.
REQ-015 The output handshake of beat WR_DAT_CYC_NUM-1 of chunk chunk_num-1 SHALL move the FSM to DONE.
REQ-016 In DONE, finish_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-017 busy_o SHALL be 1 in RUN and DONE.

Reset
REQ-018 rst_i=0 at a posedge SHALL force IDLE, clear the output stage and all counters, and drive every output to 0, including wr_target_o.
REQ-019 Reset during RUN SHALL abort the run with no finish_o pulse; the next run SHALL start from chunk 0, beat 0.

Configuration
REQ-020 With SPARSE_CHUNK_WRITER_DENSITY_STAT_EN defined, the block SHALL add output stat_nonzero_total_o, width clog2(CHUNK_NUM*MEM_SIZE+1).
- It SHALL clear on accepted start, accumulate wr_nonzero_cnt_o on each output handshake, and hold after finish_o until the next start or reset.
REQ-021 Without SPARSE_CHUNK_WRITER_DENSITY_STAT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 The shared package npu_mem_pkg SHALL hold the state enum, the target enum (TGT_IFM, TGT_FILTER) and a function computing WR_DAT_CYC_NUM.
REQ-023 A combinational sub-module sparse_beat_compactor (prefix-sum select, masking, popcount) SHALL be instantiated once.

Verification
REQ-024 The bench SHALL cover these directed scenarios with default parameters:
- Start, target 0, chunk_num 2, all beats 0x0807060504030201 with wr_ready_i=1 -> 8 beats, sparsemap 0xFF, cnt 8, counts (0,0)..(1,3), finish_o one pulse on the cycle after the last handshake.
- Beat 0x0000AA0000BB00CC -> sparsemap 0x25, data 0x0000000000AABBCC, cnt 3.
- All-zero beats, target 1 -> sparsemap 0x00, data 0, wr_target_o=1.
- wr_ready_i low for 3 cycles mid-chunk -> outputs stable, in_ready_o=0, no beat lost or duplicated.
- MEM_SIZE=20, BUS_SIZE=8, all bytes 0xFF -> third beat sparsemap 0x0F, cnt 4.
- rst_i=0 at beat 2 of chunk 1 -> all outputs 0 next cycle, no finish_o; a new start then begins at (0,0). With DENSITY_STAT_EN, the first scenario gives stat_nonzero_total_o=64.

Source files
------------

// File: rtl/npu_mem_pkg.sv
// Shared types and sizing helpers for the NPU memory write path.
package npu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        TGT_IFM    = 1'b0,
        TGT_FILTER = 1'b1
    } target_e;

    function automatic int wr_dat_cyc_num(input int mem_size, input int bus_size);
        return (mem_size + bus_size - 1) / bus_size;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational sparse compaction of one dense beat: tail masking, sparsemap,
// prefix-sum byte select and popcount.
module sparse_beat_compactor #(
    parameter int BUS_SIZE   = 8,
    parameter int LAST_BYTES = 8,
    localparam int CNT_W     = $clog2(BUS_SIZE + 1)
) (
    input  logic [BUS_SIZE*8-1:0] data_i,
    input  logic                  last_i,
    output logic [BUS_SIZE-1:0]   map_o,
    output logic [BUS_SIZE*8-1:0] nz_data_o,
    output logic [CNT_W-1:0]      cnt_o
);

    logic [CNT_W-1:0] pre [BUS_SIZE];

    always_comb begin
        map_o     = '0;
        nz_data_o = '0;
        for (int b = 0; b < BUS_SIZE; b++) begin
            pre[b] = '0;
        end
        for (int b = 0; b < BUS_SIZE; b++) begin
            map_o[b] = (|data_i[b*8 +: 8]) && !(last_i && (b >= LAST_BYTES));
        end
        for (int b = 1; b < BUS_SIZE; b++) begin
            pre[b] = pre[b-1] + CNT_W'(map_o[b-1]);
        end
        // Output slot k takes the nonzero source byte whose prefix count equals k.
        for (int k = 0; k < BUS_SIZE; k++) begin
            for (int b = 0; b < BUS_SIZE; b++) begin
                if (map_o[b] && (pre[b] == CNT_W'(k))) begin
                    nz_data_o[k*8 +: 8] = data_i[b*8 +: 8];
                end
            end
        end
        cnt_o = pre[BUS_SIZE-1] + CNT_W'(map_o[BUS_SIZE-1]);
    end

endmodule

// File: rtl/sparse_chunk_writer.sv
// Streams dense chunks into a one-stage sparse write pipeline with handshakes.
// Optional density statistic enabled by SPARSE_CHUNK_WRITER_DENSITY_STAT_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | waiting for start_i
//   ST_RUN  | accepting input beats, emitting compacted beats
//   ST_DONE | one-cycle finish_o pulse, then back to ST_IDLE
module sparse_chunk_writer
    import npu_mem_pkg::*;
#(
    parameter int BUS_SIZE  = 8,
    parameter int MEM_SIZE  = 32,
    parameter int CHUNK_NUM = 4,
    localparam int WR_DAT_CYC_NUM = wr_dat_cyc_num(MEM_SIZE, BUS_SIZE),
    localparam int DAT_W = cnt_width(WR_DAT_CYC_NUM),
    localparam int CHK_W = cnt_width(CHUNK_NUM),
    localparam int NUM_W = $clog2(CHUNK_NUM + 1),
    localparam int CNT_W = $clog2(BUS_SIZE + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  target_i,
    input  logic [NUM_W-1:0]      chunk_num_i,
    input  logic [BUS_SIZE*8-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
    output logic [CNT_W-1:0]      wr_nonzero_cnt_o,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic                  wr_target_o,
    output logic [DAT_W-1:0]      wr_dat_count_o,
    output logic [CHK_W-1:0]      wr_chunk_count_o,
    output logic                  busy_o,
    output logic                  finish_o
`ifdef SPARSE_CHUNK_WRITER_DENSITY_STAT_EN
    ,
    output logic [$clog2(CHUNK_NUM*MEM_SIZE+1)-1:0] stat_nonzero_total_o
`endif
);

    localparam int REM_W      = $clog2(CHUNK_NUM*WR_DAT_CYC_NUM + 1);
    localparam int LAST_BYTES = MEM_SIZE - (WR_DAT_CYC_NUM - 1) * BUS_SIZE;

    state_e                state_q, state_d;
    target_e               target_q;
    logic [NUM_W-1:0]      chunk_num_q;
    logic [REM_W-1:0]      rem_q;
    logic [DAT_W-1:0]      in_dat_q, out_dat_q;
    logic [CHK_W-1:0]      out_chunk_q;
    logic                  valid_q;
    logic [BUS_SIZE-1:0]   map_q, map_d;
    logic [BUS_SIZE*8-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_ok, bad_num, in_fire, out_fire;
    logic                  in_last, out_dat_last, run_last;

    assign start_ok     = (state_q == ST_IDLE) && start_i;
    assign bad_num      = (chunk_num_i == '0) || (32'(chunk_num_i) > 32'(CHUNK_NUM));
    assign in_ready_o   = (state_q == ST_RUN) && (rem_q != '0) && (!valid_q || wr_ready_i);
    assign in_fire      = in_valid_i && in_ready_o;
    assign out_fire     = valid_q && wr_ready_i;
    assign in_last      = (in_dat_q == DAT_W'(WR_DAT_CYC_NUM - 1));
    assign out_dat_last = (out_dat_q == DAT_W'(WR_DAT_CYC_NUM - 1));
    assign run_last     = out_dat_last && (NUM_W'(out_chunk_q) == chunk_num_q - NUM_W'(1));

    sparse_beat_compactor #(
        .BUS_SIZE   (BUS_SIZE),
        .LAST_BYTES (LAST_BYTES)
    ) u_compactor (
        .data_i    (in_data_i),
        .last_i    (in_last),
        .map_o     (map_d),
        .nz_data_o (data_d),
        .cnt_o     (cnt_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = bad_num ? ST_DONE : ST_RUN;
            ST_RUN:  if (out_fire && run_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            target_q    <= TGT_IFM;
            chunk_num_q <= '0;
            rem_q       <= '0;
            in_dat_q    <= '0;
            out_dat_q   <= '0;
            out_chunk_q <= '0;
            valid_q     <= 1'b0;
            map_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            // rem_q counts input beats still owed for this run.
            if (start_ok) begin
                target_q    <= target_e'(target_i);
                chunk_num_q <= chunk_num_i;
                rem_q       <= bad_num ? '0 : REM_W'(chunk_num_i) * REM_W'(WR_DAT_CYC_NUM);
                in_dat_q    <= '0;
                out_dat_q   <= '0;
                out_chunk_q <= '0;
            end
            if (in_fire) begin
                rem_q    <= rem_q - REM_W'(1);
                in_dat_q <= in_last ? '0 : in_dat_q + DAT_W'(1);
                valid_q  <= 1'b1;
                map_q    <= map_d;
                data_q   <= data_d;
                cnt_q    <= cnt_d;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
            if (out_fire) begin
                out_dat_q <= out_dat_last ? '0 : out_dat_q + DAT_W'(1);
                if (out_dat_last) out_chunk_q <= out_chunk_q + CHK_W'(1);
            end
        end
    end

    assign wr_valid_o        = valid_q;
    assign wr_sparsemap_o    = map_q;
    assign wr_nonzero_data_o = data_q;
    assign wr_nonzero_cnt_o  = cnt_q;
    assign wr_target_o       = target_q;
    assign wr_dat_count_o    = out_dat_q;
    assign wr_chunk_count_o  = out_chunk_q;
    assign busy_o            = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign finish_o          = (state_q == ST_DONE);

`ifdef SPARSE_CHUNK_WRITER_DENSITY_STAT_EN
    localparam int STAT_W = $clog2(CHUNK_NUM*MEM_SIZE + 1);

    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stat_q <= '0;
        end else if (start_ok) begin
            stat_q <= '0;
        end else if (out_fire) begin
            stat_q <= stat_q + STAT_W'(cnt_q);
        end
    end

    assign stat_nonzero_total_o = stat_q;
`endif

endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Directed self-checking bench: default instance plus a MEM_SIZE=20 instance.
module tb_sparse_chunk_writer;

    logic        clk = 1'b0;
    logic        rst_n, start_a, start_b, target, in_valid, wr_ready, sel;
    logic [2:0]  chunk_num;
    logic [63:0] in_data;

    logic        a_in_ready, a_valid, a_tgt, a_busy, a_finish;
    logic [7:0]  a_map;
    logic [63:0] a_data;
    logic [3:0]  a_cnt;
    logic [1:0]  a_dat, a_chunk;
    logic        b_in_ready, b_valid, b_tgt, b_busy, b_finish;
    logic [7:0]  b_map;
    logic [63:0] b_data;
    logic [3:0]  b_cnt;
    logic [1:0]  b_dat, b_chunk;
`ifdef SPARSE_CHUNK_WRITER_DENSITY_STAT_EN
    logic [7:0]  a_stat;
    logic [6:0]  b_stat;
`endif

    logic        m_in_ready, m_valid, m_tgt, m_busy, m_finish;
    logic [7:0]  m_map;
    logic [63:0] m_data;
    logic [3:0]  m_cnt;
    logic [1:0]  m_dat, m_chunk;

    logic [63:0] pat [8];
    logic [7:0]  exp_map [8];
    logic [63:0] exp_dat [8];
    logic [3:0]  exp_cnt [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sparse_chunk_writer u_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .target_i(target),
        .chunk_num_i(chunk_num), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(a_in_ready), .wr_sparsemap_o(a_map), .wr_nonzero_data_o(a_data),
        .wr_nonzero_cnt_o(a_cnt), .wr_valid_o(a_valid), .wr_ready_i(wr_ready),
        .wr_target_o(a_tgt), .wr_dat_count_o(a_dat), .wr_chunk_count_o(a_chunk),
        .busy_o(a_busy), .finish_o(a_finish)
`ifdef SPARSE_CHUNK_WRITER_DENSITY_STAT_EN
        , .stat_nonzero_total_o(a_stat)
`endif
    );

    sparse_chunk_writer #(.BUS_SIZE(8), .MEM_SIZE(20), .CHUNK_NUM(4)) u_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .target_i(target),
        .chunk_num_i(chunk_num), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(b_in_ready), .wr_sparsemap_o(b_map), .wr_nonzero_data_o(b_data),
        .wr_nonzero_cnt_o(b_cnt), .wr_valid_o(b_valid), .wr_ready_i(wr_ready),
        .wr_target_o(b_tgt), .wr_dat_count_o(b_dat), .wr_chunk_count_o(b_chunk),
        .busy_o(b_busy), .finish_o(b_finish)
`ifdef SPARSE_CHUNK_WRITER_DENSITY_STAT_EN
        , .stat_nonzero_total_o(b_stat)
`endif
    );

    assign m_in_ready = sel ? b_in_ready : a_in_ready;
    assign m_valid    = sel ? b_valid    : a_valid;
    assign m_tgt      = sel ? b_tgt      : a_tgt;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_finish   = sel ? b_finish   : a_finish;
    assign m_map      = sel ? b_map      : a_map;
    assign m_data     = sel ? b_data     : a_data;
    assign m_cnt      = sel ? b_cnt      : a_cnt;
    assign m_dat      = sel ? b_dat      : a_dat;
    assign m_chunk    = sel ? b_chunk    : a_chunk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_map"}, m_map, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_cnt"}, m_cnt, 0);
        chk({tag, "_target"}, m_tgt, 0);
        chk({tag, "_dat_count"}, m_dat, 0);
        chk({tag, "_chunk_count"}, m_chunk, 0);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_finish"}, m_finish, 0);
        chk({tag, "_in_ready"}, m_in_ready, 0);
    endtask

    // Entered and left at posedge+1. Output beat k must match exp_*[k].
    task automatic run(input bit s, input logic tgt, input logic [2:0] cn, input int wr,
                       input int stall_at, input int abort_at);
        int rcv, in_idx, stall, cyc, nb;
        bit fire, aborted;
        logic [7:0] pmap;
        logic [63:0] pdat;
        logic [3:0] pcnt;
        logic [1:0] pd, pc;
        nb = int'(cn) * wr;
        sel = s;
        target = tgt;
        chunk_num = cn;
        in_valid = 1'b0;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk("start_busy", m_busy, 1);
        chk("start_valid", m_valid, 0);
        rcv = 0; in_idx = 0; stall = 0; cyc = 0; aborted = 0;
        pmap = '0; pdat = '0; pcnt = '0; pd = '0; pc = '0;
        while (rcv < nb && cyc < 200 && !aborted) begin
            in_data  = (in_idx < 8) ? pat[in_idx] : 64'h0;
            in_valid = 1'b1;
            wr_ready = !(rcv == stall_at && stall < 3);
            if (stall_at >= 0 && !s) start_a = (rcv == 3);
            #1;
            fire = in_valid && m_in_ready;
            if (m_valid && !wr_ready) begin
                stall++;
                chk("stall_in_ready", m_in_ready, 0);
                if (stall > 1) begin
                    chk("stall_map_stable", m_map, pmap);
                    chk("stall_data_stable", m_data, pdat);
                    chk("stall_cnt_stable", m_cnt, pcnt);
                    chk("stall_counts_stable", {m_chunk, m_dat}, {pc, pd});
                end
                pmap = m_map; pdat = m_data; pcnt = m_cnt; pd = m_dat; pc = m_chunk;
            end else if (m_valid) begin
                chk("beat_map", m_map, exp_map[rcv]);
                chk("beat_data", m_data, exp_dat[rcv]);
                chk("beat_cnt", m_cnt, exp_cnt[rcv]);
                chk("beat_target", m_tgt, tgt);
                chk("beat_dat_count", m_dat, rcv % wr);
                chk("beat_chunk_count", m_chunk, rcv / wr);
                chk("beat_no_early_finish", m_finish, 0);
                if (rcv == abort_at) begin
                    rst_n = 1'b0;
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    chk_idle_zero("abort");
`ifdef SPARSE_CHUNK_WRITER_DENSITY_STAT_EN
                    chk("abort_stat", a_stat, 0);
`endif
                    rst_n = 1'b1;
                    repeat (3) begin
                        @(posedge clk); #1;
                        chk("abort_no_finish", m_finish, 0);
                        chk("abort_not_busy", m_busy, 0);
                    end
                    aborted = 1;
                end
                rcv++;
            end
            if (!aborted) begin
                @(posedge clk); #1;
                if (fire) in_idx++;
                cyc++;
            end
        end
        start_a  = 1'b0;
        in_valid = 1'b0;
        wr_ready = 1'b1;
        if (!aborted) begin
            chk("beats_out", rcv, nb);
            chk("beats_in", in_idx, nb);
            chk("finish_pulse", m_finish, 1);
            chk("finish_busy", m_busy, 1);
            chk("finish_drained", m_valid, 0);
            @(posedge clk); #1;
            chk("finish_one_cycle", m_finish, 0);
            chk("idle_not_busy", m_busy, 0);
        end
    endtask

    task automatic bad_start(input logic [2:0] cn);
        sel = 1'b0;
        chunk_num = cn;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("bad_num_finish", m_finish, 1);
        chk("bad_num_busy", m_busy, 1);
        chk("bad_num_valid", m_valid, 0);
        @(posedge clk); #1;
        chk("bad_num_finish_off", m_finish, 0);
        chk("bad_num_idle", m_busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; target = 1'b0;
        chunk_num = '0; in_data = '0; in_valid = 1'b0; wr_ready = 1'b1; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset_a");
        sel = 1'b1;
        #1;
        chk_idle_zero("reset_b");
        sel = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two dense chunks of 0x01..0x08.
        for (int i = 0; i < 8; i++) begin
            pat[i] = 64'h0807060504030201; exp_map[i] = 8'hFF;
            exp_dat[i] = 64'h0807060504030201; exp_cnt[i] = 4'd8;
        end
        run(1'b0, 1'b0, 3'd2, 4, -1, -1);
`ifdef SPARSE_CHUNK_WRITER_DENSITY_STAT_EN
        chk("stat_total", a_stat, 64);
`endif

        // Mixed sparsity in one chunk.
        pat[0] = 64'h0000AA0000BB00CC; exp_map[0] = 8'h25; exp_dat[0] = 64'hAABBCC;   exp_cnt[0] = 4'd3;
        pat[1] = 64'h8000000000000000; exp_map[1] = 8'h80; exp_dat[1] = 64'h80;       exp_cnt[1] = 4'd1;
        pat[2] = 64'h00FF00FF00FF00FF; exp_map[2] = 8'h55; exp_dat[2] = 64'hFFFFFFFF; exp_cnt[2] = 4'd4;
        pat[3] = 64'h0102000000000300; exp_map[3] = 8'hC2; exp_dat[3] = 64'h010203;   exp_cnt[3] = 4'd3;
        run(1'b0, 1'b0, 3'd1, 4, -1, -1);

        // All-zero beats to the filter target.
        for (int i = 0; i < 8; i++) begin
            pat[i] = 64'h0; exp_map[i] = 8'h00; exp_dat[i] = 64'h0; exp_cnt[i] = 4'd0;
        end
        run(1'b0, 1'b1, 3'd1, 4, -1, -1);

        // Distinct beats with a 3-cycle sink stall on output beat 2.
        for (int i = 0; i < 8; i++) begin
            pat[i] = 64'(i + 1) << (8 * i); exp_map[i] = 8'(1 << i);
            exp_dat[i] = 64'(i + 1); exp_cnt[i] = 4'd1;
        end
        run(1'b0, 1'b0, 3'd2, 4, 2, -1);

        // MEM_SIZE=20: last beat keeps only bytes 0..3.
        for (int i = 0; i < 8; i++) begin
            pat[i] = 64'hFFFFFFFFFFFFFFFF; exp_map[i] = 8'hFF;
            exp_dat[i] = 64'hFFFFFFFFFFFFFFFF; exp_cnt[i] = 4'd8;
        end
        exp_map[2] = 8'h0F; exp_dat[2] = 64'h00000000FFFFFFFF; exp_cnt[2] = 4'd4;
        run(1'b1, 1'b0, 3'd1, 3, -1, -1);

        bad_start(3'd0);
        bad_start(3'd5);

        // Reset at beat 2 of chunk 1, then a fresh run from (0,0).
        for (int i = 0; i < 8; i++) begin
            pat[i] = 64'h0807060504030201; exp_map[i] = 8'hFF;
            exp_dat[i] = 64'h0807060504030201; exp_cnt[i] = 4'd8;
        end
        run(1'b0, 1'b1, 3'd2, 4, -1, 6);
        run(1'b0, 1'b0, 3'd1, 4, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
